// File: rtl/clock_monitor_if.sv
// Result bundle of the clock monitor: the monitored strobe in, measurements out.
// The monitor is the slave; whoever drives sig_in and consumes results is the master.
interface clock_monitor_if #(
  parameter int unsigned CNT_WIDTH = 26
);
  logic                 sig_in;
  logic [CNT_WIDTH-1:0] period_out;
  logic [CNT_WIDTH-1:0] high_out;
  logic                 period_valid;
  logic                 stall;

  modport master (
    output sig_in,
    input  period_out, high_out, period_valid, stall
  );

  modport slave (
    input  sig_in,
    output period_out, high_out, period_valid, stall
  );
endinterface

// File: rtl/clock_monitor.sv
// Measures period and high time of a slow asynchronous strobe in clk_in cycles,
// and flags a stalled input after TIMEOUT cycles without a rising edge.
module clock_monitor #(
  parameter int unsigned          CNT_WIDTH = 26,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(50000000)
) (
  input  logic          clk_in,
  input  logic          reset,
  clock_monitor_if.slave mon
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] STALLED = 2'd2;

  logic                 s1, s2, sd;
  logic                 rise, fall;
  logic                 timed_out;
  logic [CNT_WIDTH-1:0] cnt;
  logic [1:0]           state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sd <= 1'b0;
    end else begin
      s1 <= mon.sig_in;
      s2 <= s1;
      sd <= s2;
    end
  end

  assign rise      = s2 & ~sd;
  assign fall      = ~s2 & sd;
  assign timed_out = (cnt >= TIMEOUT);

  // Cycles since the last acted-on rise; saturates so a stalled input holds at TIMEOUT.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_WIDTH'(1);
    end else if (!timed_out) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      mon.period_out   <= '0;
      mon.high_out     <= '0;
      mon.period_valid <= 1'b0;
    end else begin
      // NOTE: the valid strobe defaults low every cycle so it can only ever pulse for one cycle.
      mon.period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise)           state <= MEASURE;
          else if (timed_out) state <= STALLED;
        end
        MEASURE: begin
          if (rise) begin
            mon.period_out   <= cnt;
            mon.period_valid <= 1'b1;
          end else if (timed_out) begin
            state <= STALLED;
          end
          if (fall) mon.high_out <= cnt;
        end
        STALLED: begin
          // The period spanning the stall is meaningless, so the first rise only restarts timing.
          if (rise) state <= MEASURE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mon.stall = (state == STALLED);

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized bench for clock_monitor: two instances (long and short timeout) driven by one
// strobe and compared each cycle against an edge-time reference model, plus directed checks.
module tb_clock_monitor;

  localparam int unsigned CW    = 26;
  localparam int          TO_A  = 100;
  localparam int          TO_B  = 10;

  logic clk;
  logic reset;
  logic sig;

  clock_monitor_if #(.CNT_WIDTH(CW)) bus_a ();
  clock_monitor_if #(.CNT_WIDTH(CW)) bus_b ();

  assign bus_a.sig_in = sig;
  assign bus_b.sig_in = sig;

  clock_monitor #(.CNT_WIDTH(CW), .TIMEOUT(CW'(TO_A))) dut_a (
    .clk_in (clk),
    .reset  (reset),
    .mon    (bus_a)
  );

  clock_monitor #(.CNT_WIDTH(CW), .TIMEOUT(CW'(TO_B))) dut_b (
    .clk_in (clk),
    .reset  (reset),
    .mon    (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: tracks the clock-edge index of each acted-on edge and derives
  // outputs from edge-time differences. A strobe level captured at edge j is acted on at j+2.
  typedef enum logic [1:0] {M_IDLE, M_MEAS, M_STALL} mmode_t;
  typedef struct {
    int         k;
    int         last_rise;
    mmode_t     mode;
    logic [3:0] hist;
    int         period;
    int         high;
    bit         valid;
  } model_t;

  function automatic model_t model_init();
    model_t m;
    m.k         = 0;
    m.last_rise = 1;
    m.mode      = M_IDLE;
    m.hist      = 4'b0000;
    m.period    = 0;
    m.high      = 0;
    m.valid     = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(model_t m, logic s, int timeout);
    bit r, f;
    m.k++;
    m.hist = {m.hist[2:0], s};
    r = m.hist[2] & ~m.hist[3];
    f = ~m.hist[2] & m.hist[3];
    m.valid = 1'b0;
    if (r) begin
      if (m.mode == M_MEAS) begin
        m.period = m.k - m.last_rise;
        m.valid  = 1'b1;
      end
      m.mode      = M_MEAS;
      m.last_rise = m.k;
    end else begin
      if (f && m.mode == M_MEAS) m.high = m.k - m.last_rise;
      if (m.mode != M_STALL && (m.k - m.last_rise) >= timeout) m.mode = M_STALL;
    end
    return m;
  endfunction

  model_t ma, mb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma = model_init();
      mb = model_init();
    end else begin
      ma = model_step(ma, sig, TO_A);
      mb = model_step(mb, sig, TO_B);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("a_valid",  32'(bus_a.period_valid), 32'(ma.valid));
      check("a_period", 32'(bus_a.period_out),   ma.period);
      check("a_high",   32'(bus_a.high_out),     ma.high);
      check("a_stall",  32'(bus_a.stall),        32'(ma.mode == M_STALL));
      check("b_valid",  32'(bus_b.period_valid), 32'(mb.valid));
      check("b_period", 32'(bus_b.period_out),   mb.period);
      check("b_high",   32'(bus_b.high_out),     mb.high);
      check("b_stall",  32'(bus_b.stall),        32'(mb.mode == M_STALL));
    end
  end

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      sig = 1'b1;
      repeat (hi) @(negedge clk);
      sig = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a_period"}, 32'(bus_a.period_out),   0);
    check({tag, "_a_high"},   32'(bus_a.high_out),     0);
    check({tag, "_a_valid"},  32'(bus_a.period_valid), 0);
    check({tag, "_a_stall"},  32'(bus_a.stall),        0);
    check({tag, "_b_period"}, 32'(bus_b.period_out),   0);
    check({tag, "_b_stall"},  32'(bus_b.stall),        0);
  endtask

  initial begin
    reset = 1'b1;
    sig   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // 5 high / 5 low: period 10, high 5; short-timeout instance sees rises exactly on its timeout.
    drive_wave(5, 5, 6);
    check("sq_a_period", 32'(bus_a.period_out), 10);
    check("sq_a_high",   32'(bus_a.high_out),   5);
    check("sq_b_period", 32'(bus_b.period_out), 10);
    check("sq_b_stall",  32'(bus_b.stall),      0);

    // Duty change keeps the period.
    drive_wave(3, 7, 4);
    check("duty_a_period", 32'(bus_a.period_out), 10);
    check("duty_a_high",   32'(bus_a.high_out),   3);
    check("duty_b_stall",  32'(bus_b.stall),      0);

    // Hold low well past TIMEOUT: stall asserts, results hold.
    repeat (150) @(negedge clk);
    check("stall_a",        32'(bus_a.stall),      1);
    check("stall_a_period", 32'(bus_a.period_out), 10);
    check("stall_b",        32'(bus_b.stall),      1);

    // Recovery.
    drive_wave(5, 5, 3);
    check("recov_a_stall",  32'(bus_a.stall),      0);
    check("recov_a_period", 32'(bus_a.period_out), 10);

    // Random duty/period with occasional stalls.
    for (int i = 0; i < 150; i++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 15));
      lo = int'($urandom_range(1, 15));
      if ($urandom_range(0, 9) == 0) lo += 120;
      drive_wave(hi, lo, 1);
    end

    // Asynchronous reset mid-cycle while the strobe toggles, released with the strobe high.
    drive_wave(2, 3, 2);
    sig = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("async");
    @(negedge clk);
    sig = 1'b0;
    @(negedge clk);
    sig = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 60; i++) begin
      drive_wave(int'($urandom_range(1, 9)), int'($urandom_range(1, 9)), 1);
    end
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
# clock_monitor

Measures the period and high time of a slow, asynchronous square-wave input, such as a divided debug clock, in cycles of the fast board clock. It detects a stalled input with a timeout flag. It sits on the debug path beside the clock divider and checks divided clocks and other slow strobes on the FPGA. Results are exposed on registered outputs with a one-cycle valid pulse.

## Interface
- CNT_WIDTH, 26: width of the cycle counter and of PERIOD_OUT / HIGH_OUT.
- TIMEOUT, 26'd50000000: CLK cycles without a rising edge before STALL asserts. Must be < 2^CNT_WIDTH.
- CLK_IN  input  1: fast clock; all logic on its rising edge.
- RESET  input  1: asynchronous, active-high reset.
- SIG_IN  input  1: monitored signal, asynchronous to CLK_IN.
- PERIOD_OUT  output  CNT_WIDTH: last measured period, in CLK_IN cycles.
- HIGH_OUT  output  CNT_WIDTH: last measured high time, in CLK_IN cycles.
- PERIOD_VALID  output  1: one-cycle pulse when PERIOD_OUT is updated.
- STALL  output  1: high while in the STALLED state.

## Operation
- **Synchronizer.** SIG_IN passes through a 2-FF synchronizer (s1, s2) and then a delay flop sd. All three reset to 0.
  - rise = s2 & ~sd
  - fall = ~s2 & sd
- **Counter cnt.** Width CNT_WIDTH.
  - On rise: cnt <= 1.
  - Otherwise: cnt <= cnt + 1, saturating at TIMEOUT.
  - This applies in every state.
- **State machine.** Three states: IDLE, MEASURE, STALLED. Reset state is IDLE.
- **IDLE**
  - rise → MEASURE, with no PERIOD_VALID pulse (the first edge only starts timing).
  - No rise and cnt == TIMEOUT → STALLED.
  - fall is ignored.
- **MEASURE**
  - rise → PERIOD_OUT <= cnt, PERIOD_VALID <= 1; stay in MEASURE.
  - fall → HIGH_OUT <= cnt.
  - No rise and cnt == TIMEOUT → STALLED. PERIOD_OUT and HIGH_OUT hold.
- **STALLED**
  - STALL = 1.
  - rise → MEASURE, STALL clears, no PERIOD_VALID. The period spanning the stall is discarded.
  - fall is ignored.
- **Priority.** rise beats timeout on the same edge.
- **Outputs.** PERIOD_OUT and HIGH_OUT hold their values between updates. HIGH_OUT may update before the first PERIOD_VALID.
- **Reset values.** Asserting RESET at any time, including mid-measurement, immediately sets:
  - PERIOD_OUT = 0, HIGH_OUT = 0, PERIOD_VALID = 0, STALL = 0
  - cnt = 0, s1/s2/sd = 0, state = IDLE
- **SIG_IN high at reset release.** This produces a rise about 2 cycles later and counts as the first edge.

## Timing
- **Edge latency.** If SIG_IN toggles and is sampled by s1 at CLK edge n, rise/fall is true between edges n+1 and n+2. The resulting register updates occur at edge n+2. PERIOD_VALID is high for the single cycle after edge n+2.
- **Period value.** Two rises acted on at edges a and b give PERIOD_OUT = b − a.
- **High-time value.** A fall acted on at edge f gives HIGH_OUT = f − a.
- **Synchronizer jitter.** ±1 cycle of jitter per edge is inherent to synchronization and is accepted.
- **Stall timing.** STALL rises on the edge where cnt == TIMEOUT is observed without a rise, i.e. TIMEOUT cycles after the last acted-on rise (or after reset). STALL falls on the edge that acts on the next rise.
- **Maximum rate.** The minimum measurable high or low phase is 1 CLK_IN cycle; shorter pulses may be missed.
- **No handshake.** The consumer samples PERIOD_OUT when PERIOD_VALID is high. The value stays stable until the next pulse.

## Test plan
- **Reset:** assert RESET mid-cycle with SIG_IN toggling → all outputs are 0 asynchronously; after release there is no PERIOD_VALID until two rises have been seen.
- **Square wave 5 high / 5 low, synchronous to CLK_IN:**
  - First PERIOD_VALID occurs at the second rise, with PERIOD_OUT = 10 and HIGH_OUT = 5.
  - Every subsequent rise pulses PERIOD_VALID with PERIOD_OUT = 10.
- **Duty change to 3 high / 7 low:** PERIOD_OUT stays 10 and HIGH_OUT = 3 from the first full cycle after the change.
- **Stall (TIMEOUT = 100):** in MEASURE, hold SIG_IN low → STALL asserts exactly 100 cycles after the last acted-on rise; PERIOD_OUT keeps its previous value; no PERIOD_VALID.
- **Recovery:** resume the 10-cycle wave after the stall → STALL clears at the first rise with no PERIOD_VALID; the next rise gives PERIOD_VALID with PERIOD_OUT = 10.
- **Rise on the timeout edge (TIMEOUT = 10, period exactly 10):** the rise coincides with cnt == 10 → no STALL; PERIOD_VALID with PERIOD_OUT = 10.
